// File: rtl/serv_seq_pkg.sv
// serv_seq_pkg: state encodings and register width for the serial sequencer (SERV_SEQ_MDU_EN adds SEQ_MDU_WAIT)
package serv_seq_pkg;
  localparam int SEQ_XLEN = 32;
  typedef enum logic [2:0] {
    SEQ_BOOT,
    SEQ_FETCH,
    SEQ_WAIT_INSN,
    SEQ_INIT,
    SEQ_MEM_WAIT,
    SEQ_RUN
`ifdef SERV_SEQ_MDU_EN
    , SEQ_MDU_WAIT
`endif
  } state_t;
  function automatic logic is_phase(input state_t s);
    return s == SEQ_INIT || s == SEQ_RUN;
  endfunction
endpackage

// File: rtl/serv_seq_cnt.sv
// serv_seq_cnt: serial bit-position counter with clear/enable and first/last flags
module serv_seq_cnt #(
  parameter int N = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt0,
  output logic             done
);
  // N is a power of two, so the natural overflow gives the N-1 -> 0 wrap
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? '0 : en ? cnt + CNT_W'(1) : cnt;
  assign cnt0 = en && cnt == '0;
  assign done = en && cnt == CNT_W'(N - 1);
endmodule

// File: rtl/serv_seq.sv
// serv_seq: fetch/init/mem-wait/run sequencer for a W-bit serial core
// SERV_SEQ_MDU_EN adds the multiply/divide handshake and MDU_WAIT state.
module serv_seq import serv_seq_pkg::*; #(
  parameter int W = 1,
  parameter int XLEN = SEQ_XLEN,
  localparam int CNT_W = $clog2(XLEN / W)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_i_ca_vld,
  input  logic             i_i_ca_rdy,
  output logic             o_i_rd_rdy,
  input  logic             i_i_rd_vld,
  input  logic             i_two_stage,
  input  logic             i_mem_op,
  output logic             o_mem_req,
  input  logic             i_mem_rdy,
`ifdef SERV_SEQ_MDU_EN
  input  logic             i_mdu_op,
  output logic             o_mdu_vld,
  input  logic             i_mdu_rdy,
`endif
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_cnt0,
  output logic             o_cnt_done,
  output logic             o_init,
  output logic             o_run,
  output logic             o_ctrl_en
);
  localparam int N = XLEN / W;
  state_t state, next;
  logic mem_req, phase;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= SEQ_BOOT;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      SEQ_BOOT:      next = SEQ_FETCH;
      SEQ_FETCH:     if (i_i_ca_rdy) next = SEQ_WAIT_INSN;
      SEQ_WAIT_INSN: if (i_i_rd_vld) next = i_two_stage ? SEQ_INIT : SEQ_RUN;
`ifdef SERV_SEQ_MDU_EN
      SEQ_INIT:      if (o_cnt_done) next = i_mdu_op ? SEQ_MDU_WAIT : i_mem_op ? SEQ_MEM_WAIT : SEQ_RUN;
      SEQ_MDU_WAIT:  if (i_mdu_rdy) next = SEQ_RUN;
`else
      SEQ_INIT:      if (o_cnt_done) next = i_mem_op ? SEQ_MEM_WAIT : SEQ_RUN;
`endif
      SEQ_MEM_WAIT:  if (i_mem_rdy) next = SEQ_RUN;
      SEQ_RUN:       if (o_cnt_done) next = SEQ_FETCH;
      default:       next = SEQ_BOOT;
    endcase
  end
  // request fires only on entry so a long memory wait never re-issues it
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) mem_req <= 1'b0;
    else mem_req <= next == SEQ_MEM_WAIT && state != SEQ_MEM_WAIT;
  assign phase = is_phase(state);
  serv_seq_cnt #(.N(N), .CNT_W(CNT_W)) u_cnt (
    .clk  (i_clk),
    .rst  (i_rst),
    .clr  (!phase),
    .en   (phase),
    .cnt  (o_cnt),
    .cnt0 (o_cnt0),
    .done (o_cnt_done)
  );
  assign o_mem_req  = mem_req;
  assign o_i_ca_vld = state == SEQ_FETCH;
  assign o_i_rd_rdy = state == SEQ_WAIT_INSN;
  assign o_init     = state == SEQ_INIT;
  assign o_run      = state == SEQ_RUN;
  assign o_ctrl_en  = o_run;
`ifdef SERV_SEQ_MDU_EN
  assign o_mdu_vld  = state == SEQ_MDU_WAIT;
`endif
endmodule

// File: tb/tb_serv_seq.sv
// tb_serv_seq: scoreboard bench for serv_seq at W=1 and W=4 (MDU scenario under SERV_SEQ_MDU_EN)
module tb_serv_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic two_stage = 1'b0, mem_op = 1'b0, mdu_op = 1'b0;
  logic [3:0] st1 = '0, st4 = '0;
  logic sel = 1'b0;
  logic a_ca, a_rd, a_mreq, a_c0, a_dn, a_init, a_run, a_ctrl, a_mv;
  logic b_ca, b_rd, b_mreq, b_c0, b_dn, b_init, b_run, b_ctrl, b_mv;
  logic [4:0] a_cnt;
  logic [2:0] b_cnt;
  logic [13:0] obs;
  typedef struct packed {logic [3:0] st; logic [13:0] exp;} ent_t;
  ent_t q[$];
  int total = 0, errs = 0;

  serv_seq #(.W(1)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .o_i_ca_vld(a_ca), .i_i_ca_rdy(st1[3]),
    .o_i_rd_rdy(a_rd), .i_i_rd_vld(st1[2]),
    .i_two_stage(two_stage), .i_mem_op(mem_op),
    .o_mem_req(a_mreq), .i_mem_rdy(st1[1]),
`ifdef SERV_SEQ_MDU_EN
    .i_mdu_op(mdu_op), .o_mdu_vld(a_mv), .i_mdu_rdy(st1[0]),
`endif
    .o_cnt(a_cnt), .o_cnt0(a_c0), .o_cnt_done(a_dn),
    .o_init(a_init), .o_run(a_run), .o_ctrl_en(a_ctrl)
  );
  serv_seq #(.W(4)) dut4 (
    .i_clk(clk), .i_rst(rst),
    .o_i_ca_vld(b_ca), .i_i_ca_rdy(st4[3]),
    .o_i_rd_rdy(b_rd), .i_i_rd_vld(st4[2]),
    .i_two_stage(two_stage), .i_mem_op(mem_op),
    .o_mem_req(b_mreq), .i_mem_rdy(st4[1]),
`ifdef SERV_SEQ_MDU_EN
    .i_mdu_op(mdu_op), .o_mdu_vld(b_mv), .i_mdu_rdy(st4[0]),
`endif
    .o_cnt(b_cnt), .o_cnt0(b_c0), .o_cnt_done(b_dn),
    .o_init(b_init), .o_run(b_run), .o_ctrl_en(b_ctrl)
  );
`ifndef SERV_SEQ_MDU_EN
  assign a_mv = 1'b0;
  assign b_mv = 1'b0;
`endif
  assign obs = sel ? {b_ca, b_rd, b_init, b_run, b_ctrl, b_mreq, b_mv, b_c0, b_dn, 2'b00, b_cnt}
                   : {a_ca, a_rd, a_init, a_run, a_ctrl, a_mreq, a_mv, a_c0, a_dn, a_cnt};

  task automatic push(input logic [3:0] st, input logic ca, rd, ini, run, mr, mv, c0, dn, input int c);
    q.push_back(ent_t'({st, ca, rd, ini, run, run, mr, mv, c0, dn, 5'(c)}));
  endtask

  // Expected timeline of one instruction from its FETCH cycle; stim is applied after each cycle's compare
  task automatic push_insn(input int n, input logic two, mem, mdu, input int wd, input int stray);
    push(4'b1000, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    push(4'b0100, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    if (two)
      for (int i = 0; i < n; i++) push(i == stray ? 4'b0010 : 4'b0000, 0, 0, 1, 0, 0, 0, i == 0, i == n - 1, i);
    if (mdu)
      for (int k = 0; k <= wd; k++) push(k == wd ? 4'b0001 : 4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    else if (mem)
      for (int k = 0; k <= wd; k++) push(k == wd ? 4'b0010 : 4'b0000, 0, 0, 0, 0, k == 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) push(4'b0000, 0, 0, 0, 1, 0, 0, i == 0, i == n - 1, i);
  endtask

  task automatic drive(input logic [3:0] s);
    if (sel) st4 = s;
    else st1 = s;
  endtask

  task automatic test_reset;
    ent_t e;
    int cyc = 0;
    sel = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #1 total++;
      if (obs !== 14'h0) begin errs++; $display("FAIL reset_hold dut%0d got %h want %h", d, obs, 14'h0); end
    end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 total++;
    if (obs !== 14'h0) begin errs++; $display("FAIL boot_cycle got %h want %h", obs, 14'h0); end
    push_insn(32, 0, 0, 0, 0, -1);
    push_insn(32, 0, 0, 0, 0, -1);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (obs !== e.exp) begin errs++; $display("FAIL add_w1 cyc%0d got %h want %h", cyc, obs, e.exp); end
      drive(e.st);
      cyc++;
    end
    drive(4'b0000);
  endtask

  task automatic test_branch;
    ent_t e;
    int cyc = 0;
    sel = 1'b1;
    two_stage = 1'b1;
    mem_op = 1'b0;
    push_insn(8, 1, 0, 0, 0, -1);
    push_insn(8, 1, 0, 0, 0, 3);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (obs !== e.exp) begin errs++; $display("FAIL branch_w4 cyc%0d got %h want %h", cyc, obs, e.exp); end
      drive(e.st);
      cyc++;
    end
    drive(4'b0000);
    sel = 1'b0;
  endtask

  task automatic test_load;
    ent_t e;
    int cyc = 0;
    sel = 1'b0;
    two_stage = 1'b1;
    mem_op = 1'b1;
    push_insn(32, 1, 1, 0, 5, -1);
    push_insn(32, 1, 1, 0, 0, -1);
    push_insn(32, 1, 1, 0, 2, 5);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (obs !== e.exp) begin errs++; $display("FAIL load_w1 cyc%0d got %h want %h", cyc, obs, e.exp); end
      drive(e.st);
      cyc++;
    end
    drive(4'b0000);
  endtask

  task automatic test_reset_mid;
    ent_t e;
    int cyc = 0;
    sel = 1'b0;
    two_stage = 1'b0;
    mem_op = 1'b0;
    push(4'b1000, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    push(4'b0100, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i <= 10; i++) push(4'b0000, 0, 0, 0, 1, 0, 0, i == 0, 0, i);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (obs !== e.exp) begin errs++; $display("FAIL pre_reset cyc%0d got %h want %h", cyc, obs, e.exp); end
      drive(e.st);
      cyc++;
    end
    rst = 1'b1;
    #1 total++;
    if (obs !== 14'h0) begin errs++; $display("FAIL async_reset got %h want %h", obs, 14'h0); end
    @(negedge clk);
    rst = 1'b0;
    #1 total++;
    if (obs !== 14'h0) begin errs++; $display("FAIL reboot_cycle got %h want %h", obs, 14'h0); end
    cyc = 0;
    push_insn(32, 0, 0, 0, 0, -1);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (obs !== e.exp) begin errs++; $display("FAIL post_reset cyc%0d got %h want %h", cyc, obs, e.exp); end
      drive(e.st);
      cyc++;
    end
    drive(4'b0000);
  endtask

`ifdef SERV_SEQ_MDU_EN
  task automatic test_mdu;
    ent_t e;
    int cyc = 0;
    sel = 1'b0;
    two_stage = 1'b1;
    mem_op = 1'b1;
    mdu_op = 1'b1;
    push_insn(32, 1, 1, 1, 3, -1);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (obs !== e.exp) begin errs++; $display("FAIL mdu_w1 cyc%0d got %h want %h", cyc, obs, e.exp); end
      drive(e.st);
      cyc++;
    end
    drive(4'b0000);
    mdu_op = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d compared", total);
    $fatal(1);
  end

  initial begin
    test_reset;
    test_branch;
    test_load;
    test_reset_mid;
`ifdef SERV_SEQ_MDU_EN
    test_mdu;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, errs);
    $finish;
  end
endmodule
